// File: rtl/xalu_muldiv.sv
// xalu_muldiv: multi-cycle multiply/divide unit owning the HI/LO registers.
// Multiplies take MULT_LATENCY busy cycles; divides run a radix-2 restoring
// loop of DIV_ITER iterations followed by one sign-fix cycle.
// Optional build macro XALU_DIV_ZERO_FAST_EN: divide by zero skips the
// iteration loop and goes straight to the fix cycle (one busy cycle).
// Handshake: a request is accepted on a rising edge where start=1, busy=0 and
// flush=0; done pulses for one cycle after a mult/div/mul result is written;
// flush cancels both a pending request and any in-flight operation.
module xalu_muldiv #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_ITER     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [31:0] a_reg, b_reg;
  logic        is_signed, is_mul;
  logic [31:0] rem, quo, dvs;
  logic        sign_a, sign_b, div_zero;

  logic        accept, is_mult_op, is_div_op, div_signed;
  logic        mult_last, div_last;
  logic [31:0] mag_a, mag_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] rem_sh, diff;

  assign accept     = start && !flush && (state == S_IDLE);
  assign is_mult_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
  assign is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
  assign div_signed = (op == OP_DIV);
  assign mag_a      = (div_signed && src_a[31]) ? -src_a : src_a;
  assign mag_b      = (div_signed && src_b[31]) ? -src_b : src_b;
  assign mult_last  = (cnt == 6'(MULT_LATENCY - 1));
  assign div_last   = (cnt == 6'(DIV_ITER - 1));
  assign busy       = (state != S_IDLE);

  // Product of the latched operands, sign- or zero-extended to 64 bits.
  always_comb begin
    ext_a = is_signed ? {{32{a_reg[31]}}, a_reg} : {32'b0, a_reg};
    ext_b = is_signed ? {{32{b_reg[31]}}, b_reg} : {32'b0, b_reg};
    prod  = ext_a * ext_b;
  end

  // One restoring-divide step: shift in next dividend bit, trial subtract.
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvs};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mult_op) state_next = S_MULT;
        else if (accept && is_div_op) begin
`ifdef XALU_DIV_ZERO_FAST_EN
          state_next = (src_b == 32'd0) ? S_FIX : S_DIV;
`else
          state_next = S_DIV;
`endif
        end
      end
      S_MULT:  if (mult_last) state_next = S_IDLE;
      S_DIV:   if (div_last) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Datapath: operand capture, iteration, and HI/LO/mul_result writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      is_signed  <= 1'b0;
      is_mul     <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      div_zero   <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      mul_result <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          cnt <= '0;
          if (op == OP_MTHI) hi <= src_a;
          if (op == OP_MTLO) lo <= src_a;
          if (is_mult_op) begin
            a_reg     <= src_a;
            b_reg     <= src_b;
            is_signed <= (op != OP_MULTU);
            is_mul    <= (op == OP_MUL);
          end
          if (is_div_op) begin
            a_reg    <= src_a;
            sign_a   <= div_signed && src_a[31];
            sign_b   <= div_signed && src_b[31];
            div_zero <= (src_b == 32'd0);
            rem      <= '0;
            quo      <= mag_a;
            dvs      <= mag_b;
          end
        end
      end else if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          S_MULT: begin
            cnt <= cnt + 6'd1;
            if (mult_last) begin
              done <= 1'b1;
              if (is_mul) mul_result <= prod[31:0];
              else begin
                hi <= prod[63:32];
                lo <= prod[31:0];
              end
            end
          end
          S_DIV: begin
            cnt <= cnt + 6'd1;
            if (!diff[32]) begin
              rem <= diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= rem_sh[31:0];
              quo <= {quo[30:0], 1'b0};
            end
          end
          S_FIX: begin
            done <= 1'b1;
            cnt  <= '0;
            if (div_zero) begin
              hi <= a_reg;
              lo <= 32'hFFFF_FFFF;
            end else begin
              lo <= (sign_a ^ sign_b) ? -quo : quo;
              hi <= sign_a ? -rem : rem;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU/MUL/MTHI/MTLO.
- Drives the XALU_Busy indication consumed by decode-stage stall control, which holds any HI/LO-family instruction while an operation is in flight.

Parameters:
MULT_LATENCY, 4, busy cycles for MULT/MULTU/MUL (range 1..8); product registered at the end.
DIV_ITER, 32, radix-2 restoring-divide iterations; fixed at 32, one sign-fix cycle follows.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only when busy==0 and flush==0
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MUL, 7 reserved (no-op)
src_a  input  32  rs operand / dividend
src_b  input  32  rt operand / divisor
flush  input  1  exception flush; cancels request and in-flight operation
busy  output  1  operation in flight (to stall control as XALU_Busy)
done  output  1  one-cycle pulse when a mult/div/mul completes
hi  output  32  HI register
lo  output  32  LO register
mul_result  output  32  low 32 bits of the last MUL product (GPR writeback)

Behaviour:
- Reset: busy=0, done=0, hi=0, lo=0, mul_result=0, FSM=IDLE, counters=0. Reset mid-operation abandons it; HI/LO forced to 0.
- FSM states: IDLE, MULT, DIV, FIX.
- Accepted start (start && !busy && !flush):
  - MTHI: hi<=src_a at that edge; busy stays 0; no done.
  - MTLO: lo<=src_a at that edge; busy stays 0; no done.
  - op 7: ignored.
  - MULT/MULTU/MUL: enter MULT; operands latched; busy=1 from next cycle for exactly MULT_LATENCY cycles.
    - On the final edge: busy->0, done=1 for one cycle.
    - MULT/MULTU: {hi,lo}<=64-bit product (signed or unsigned).
    - MUL: mul_result<=product[31:0]; hi/lo unchanged.
  - DIV/DIVU: enter DIV; latch magnitudes and signs; 32 iteration cycles, then FIX (1 cycle); busy high 33 cycles total.
    - On the FIX edge: lo<=quotient, hi<=remainder, busy->0, done pulse.
- Arithmetic rules:
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divide by zero, any sign: hi=src_a, lo=0xFFFFFFFF.
- start while busy=1: ignored, no state change (stall control guarantees none arrives; bench checks no corruption).
- flush:
  - High in the start cycle: request dropped, MTHI/MTLO included.
  - High while busy: FSM->IDLE at that edge, busy=0 next cycle, no done, hi/lo/mul_result keep pre-operation values.
- done and busy are never both 1. done is always 0 in the cycle after a flush.
- hi/lo/mul_result are plain register outputs, with no combinational path from inputs.

Optional Feature:
XALU_DIV_ZERO_FAST_EN:
- Defined: DIV/DIVU with src_b==0 skips DIV/FIX. busy=1 for exactly one cycle, then hi=src_a, lo=0xFFFFFFFF, done pulse.
- Undefined: divide by zero takes the full 33 cycles with the same final hi/lo values.
- All other ops are identical in both builds.

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy high 4 cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MUL 7*6 -> mul_result=42, hi/lo unchanged.
- DIV -7/2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 on back-to-back cycles -> hi=0x1234, lo=0x5678; busy never asserts.
- DIV 50/5 with flush at iteration 10 -> busy low next cycle, no done, hi/lo unchanged. Repeat with flush in the start cycle -> nothing starts.
- DIVU 9/0 -> hi=9, lo=0xFFFFFFFF; busy 1 cycle with XALU_DIV_ZERO_FAST_EN, 33 cycles without. Mid-DIV reset -> all outputs 0 next cycle.
